// File: rtl/mips_shift_pkg.sv
// Shared op encodings, FSM states and default widths for the serial shifter.
// Rotate decode depends on MIPS_SHIFTER_ROTATE_EN; without it ROR/ROL behave as LOAD.
package mips_shift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;
    localparam logic [2:0] SH_ROL  = 3'b110;
    localparam logic [2:0] SH_NOP2 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for ops that spend cycles in SHIFT when shamt is nonzero.
    function automatic logic is_shift_op(input logic [2:0] op);
        case (op)
            SH_SLL, SH_SRL, SH_SRA: is_shift_op = 1'b1;
`ifdef MIPS_SHIFTER_ROTATE_EN
            SH_ROR, SH_ROL:         is_shift_op = 1'b1;
`endif
            default:                is_shift_op = 1'b0;
        endcase
    endfunction

    // Everything except the two NOP codes captures the operand.
    function automatic logic op_loads(input logic [2:0] op);
        op_loads = (op != SH_NOP) && (op != SH_NOP2);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step of the result register, purely combinational, zero latency.
// No handshake; rotate cases exist only with MIPS_SHIFTER_ROTATE_EN.
module shift_step
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] sr_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] sr_o
);

    always_comb begin
        sr_o = sr_i;
        case (op_i)
            SH_SLL: sr_o = {sr_i[WIDTH-2:0], 1'b0};
            SH_SRL: sr_o = {1'b0, sr_i[WIDTH-1:1]};
            SH_SRA: sr_o = {sr_i[WIDTH-1], sr_i[WIDTH-1:1]};
`ifdef MIPS_SHIFTER_ROTATE_EN
            SH_ROR: sr_o = {sr_i[0], sr_i[WIDTH-1:1]};
            SH_ROL: sr_o = {sr_i[WIDTH-2:0], sr_i[WIDTH-1]};
`endif
            default: sr_o = sr_i;
        endcase
    end

endmodule

// File: rtl/mips_serial_shifter.sv
// Serial shifter: one bit per clock, start/busy/done handshake; optional rotates via MIPS_SHIFTER_ROTATE_EN.
// Latency: shamt+1 cycles from accepted start to done (1 for LOAD/NOP/shamt=0).
// Backpressure: start is ignored while busy; a start during DONE is accepted back-to-back.
module mips_serial_shifter
    import mips_shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   sr_step;
    logic               accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .sr_i (sr_q),
        .op_i (op_q),
        .sr_o (sr_step)
    );

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (accept) begin
            op_d  = op;
            cnt_d = shamt;
            if (op_loads(op)) begin
                sr_d = data_in;
            end
            state_d = (is_shift_op(op) && (shamt != '0)) ? ST_SHIFT : ST_DONE;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    sr_d  = sr_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Reset discards any partial result, including mid-shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            op_q    <= SH_NOP;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign data_out = sr_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mips_serial_shifter.sv
// Directed vector bench for mips_serial_shifter; rotate expectations follow MIPS_SHIFTER_ROTATE_EN.
module tb_mips_serial_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    mips_serial_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  shamt;
        logic [31:0] din;
        logic [31:0] exp_out;
        int          exp_busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one op, then follow it to done; returns busy cycles, latency, result.
    task automatic do_op(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d,
                         output int busy_n, output int lat, output logic [31:0] res,
                         output bit timed_out, output bit overlap);
        @(negedge clk);
        start = 1'b1; op = o; shamt = s; data_in = d;
        @(posedge clk);
        #1 start = 1'b0;
        busy_n = 0; lat = 0; res = '0; timed_out = 1'b1; overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                timed_out = 1'b0;
                res = data_out;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    vec_t        vecs[$];
    int          bn, lat, dcount;
    logic [31:0] res;
    bit          to, ov;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{3'b100, 5'd4,  32'h8000_0010, 32'hF800_0001, 4});
        vecs.push_back('{3'b011, 5'd4,  32'h8000_0010, 32'h0800_0001, 4});
        vecs.push_back('{3'b010, 5'd0,  32'h1234_5678, 32'h1234_5678, 0});
        vecs.push_back('{3'b001, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0});
        vecs.push_back('{3'b000, 5'd3,  32'h1111_1111, 32'hDEAD_BEEF, 0});
        vecs.push_back('{3'b010, 5'd31, 32'h0000_0001, 32'h8000_0000, 31});
        vecs.push_back('{3'b100, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 31});
        vecs.push_back('{3'b100, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31});
        vecs.push_back('{3'b010, 5'd8,  32'hA5A5_A5A5, 32'hA5A5_A500, 8});
`ifdef MIPS_SHIFTER_ROTATE_EN
        vecs.push_back('{3'b101, 5'd1,  32'h0000_0001, 32'h8000_0000, 1});
        vecs.push_back('{3'b110, 5'd1,  32'h8000_0000, 32'h0000_0001, 1});
        vecs.push_back('{3'b111, 5'd5,  32'h0F0F_0F0F, 32'h0000_0001, 0});
        vecs.push_back('{3'b101, 5'd4,  32'h1234_5678, 32'h8123_4567, 4});
`else
        vecs.push_back('{3'b101, 5'd1,  32'h0000_0001, 32'h0000_0001, 0});
        vecs.push_back('{3'b110, 5'd1,  32'h8000_0000, 32'h8000_0000, 0});
        vecs.push_back('{3'b111, 5'd5,  32'h0F0F_0F0F, 32'h8000_0000, 0});
        vecs.push_back('{3'b101, 5'd4,  32'h1234_5678, 32'h1234_5678, 0});
`endif

        reset = 1'b1; start = 1'b0; op = 3'b000; shamt = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_data", data_out, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].shamt, vecs[i].din, bn, lat, res, to, ov);
            chk($sformatf("vec%0d_timeout", i), {31'b0, to}, 32'h0);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp_out);
            chk($sformatf("vec%0d_busy_cycles", i), bn, vecs[i].exp_busy);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_busy + 1);
            chk($sformatf("vec%0d_overlap", i), {31'b0, ov}, 32'h0);
        end

        // Reset in the middle of a long shift.
        @(negedge clk);
        start = 1'b1; op = 3'b010; shamt = 5'd20; data_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("midrst_no_activity", dcount, 0);
        chk("midrst_data_hold", data_out, 32'h0);

        // Back-to-back: second start accepted in the DONE cycle.
        do_op(3'b010, 5'd31, 32'h0000_0001, bn, lat, res, to, ov);
        chk("b2b_first_data", res, 32'h8000_0000);
        chk("b2b_first_latency", lat, 32);
        start = 1'b1; op = 3'b011; shamt = 5'd31; data_in = 32'h8000_0000;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle_busy", {31'b0, busy}, 32'h1);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        chk("b2b_second_timeout", {31'b0, to}, 32'h0);
        chk("b2b_second_data", data_out, 32'h0000_0001);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b010; shamt = 5'd6; data_in = 32'h0000_0003;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 begin start = 1'b1; op = 3'b011; shamt = 5'd1; data_in = 32'hFFFF_FFFF; end
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0; lat = 0; res = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (dcount == 1) begin res = data_out; lat = i + 4; end
            end
        end
        chk("ignore_done_count", dcount, 1);
        chk("ignore_data", res, 32'h0000_00C0);
        chk("ignore_latency", lat, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
